debug_uart_tx_fifo: RTL

DEBUG_UART_TX_FIFO -- requirements
Module: debug_uart_tx_fifo

---
 rtl/tinyqv_uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/debug_uart_tx_fifo.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tinyqv_uart_pkg.sv
// Shared UART definitions: serialiser state encoding and baud divisor width.
package tinyqv_uart_pkg;

  localparam int unsigned DivWidth = 16;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  // A divisor below 2 cannot time a bit; clamp it.
  function automatic logic [DivWidth-1:0] clamp_div(input logic [DivWidth-1:0] d);
    return (d < DivWidth'(2)) ? DivWidth'(2) : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage and an occupancy counter; shared by TX and RX paths.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_wr, do_rd;

  always_comb begin
    full  = (level_q == (AW+1)'(DEPTH));
    empty = (level_q == '0);
    do_rd = rd_en && !empty;
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    do_wr = wr_en && (!full || do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter: FIFO-buffered bytes serialised 8N1-style with a runtime baud divisor.
module debug_uart_tx_fifo
  import tinyqv_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 14_000_000,
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          div_we,
  input  logic [DivWidth-1:0]           div_in,
  input  logic                          ovf_clr,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          tx_done_irq
);

  localparam logic [DivWidth-1:0] ResetDiv = clamp_div(DivWidth'(CLK_HZ / BIT_RATE));
  localparam logic [3:0]          LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]          LastStop = 4'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic [DivWidth-1:0]  div_q, frame_div_q, baud_q, next_div;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q, head;
  logic                 txd_q, irq_q, ovf_q;
  logic                 fifo_empty, bit_end, frame_end, pop, drop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    bit_end   = (baud_q == frame_div_q - DivWidth'(1));
    frame_end = (state_q == StStop) && bit_end && (bit_q == LastStop);
    pop       = !fifo_empty && ((state_q == StIdle) || frame_end);
    drop      = wr_en && fifo_full && !pop;
    next_div  = div_we ? clamp_div(div_in) : div_q;
  end

  // Programmed divisor; only copied into frame_div_q when a frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= ResetDiv;
    end else if (div_we) begin
      div_q <= clamp_div(div_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      frame_div_q <= ResetDiv;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            state_q     <= StStart;
            txd_q       <= 1'b0;
            baud_q      <= '0;
            shift_q     <= head;
            frame_div_q <= next_div;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + DivWidth'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == LastData) begin
              state_q <= StStop;
              bit_q   <= '0;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 4'd1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + DivWidth'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == LastStop) begin
              bit_q <= '0;
              // Chain straight into the next start bit when more data is queued.
              if (pop) begin
                state_q     <= StStart;
                txd_q       <= 1'b0;
                shift_q     <= head;
                frame_div_q <= next_div;
              end else begin
                state_q <= StIdle;
                irq_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            baud_q <= baud_q + DivWidth'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_txd    = txd_q;
  assign tx_done_irq = irq_q;
  assign overflow    = ovf_q;
  assign tx_busy     = (state_q != StIdle) || (fifo_level != '0);

endmodule
